// File: rtl/ethernet_st_frame_checker.sv
// Avalon-ST Ethernet frame checker: framing/length validation, 6-bit per-packet error vector,
// registered output stage with a one-entry skid buffer.
module ethernet_st_frame_checker #(
  parameter int unsigned MIN_BYTES = 64,
  parameter int unsigned MAX_BYTES = 1518,
  parameter int unsigned COUNT_W   = 16
) (
  input  logic        clk,
  input  logic        reset,
  output logic        in_ready,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  input  logic        in_startofpacket,
  input  logic        in_endofpacket,
  input  logic [1:0]  in_empty,
  input  logic        in_error,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [31:0] out_data,
  output logic [5:0]  out_error,
  output logic        out_startofpacket,
  output logic        out_endofpacket,
  output logic [1:0]  out_empty,
  output logic        stat_drop,
  output logic        stat_pkt
);

  localparam int unsigned SumW = COUNT_W + 2;
  localparam logic [COUNT_W-1:0] MinB = COUNT_W'(MIN_BYTES);
  localparam logic [COUNT_W-1:0] MaxB = COUNT_W'(MAX_BYTES);
  localparam logic [SumW-1:0]    CntMax = {2'b00, {COUNT_W{1'b1}}};

  typedef enum logic [0:0] {StIdle, StInPkt} state_e;

  typedef struct packed {
    logic [5:0]  error;
    logic [1:0]  empty;
    logic        eop;
    logic        sop;
    logic [31:0] data;
  } beat_t;

  state_e             st_q, st_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d;
  logic [5:0]         err_q, err_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  beat_t              out_q, out_d;
  logic               skid_valid_q, skid_valid_d;
  beat_t              skid_q, skid_d;

  logic               acc;
  logic               beat_fwd;
  logic               out_fire;
  logic [COUNT_W-1:0] cnt_base;
  logic [SumW-1:0]    cnt_sum;
  logic               cnt_sat;
  logic [COUNT_W-1:0] cnt_new;
  logic [5:0]         err_base;
  logic [5:0]         err_new;
  beat_t              beat;

  // Per-beat count and error evaluation on the input side.
  always_comb begin
    acc      = in_valid & in_ready_q & ~reset;
    cnt_base = in_startofpacket ? '0 : cnt_q;
    cnt_sum  = {2'b00, cnt_base} + SumW'(4)
             - (in_endofpacket ? SumW'(in_empty) : SumW'(0));
    cnt_sat  = (cnt_sum >= CntMax);
    cnt_new  = cnt_sat ? {COUNT_W{1'b1}} : cnt_sum[COUNT_W-1:0];

    // A sop restarts the sticky vector; bit0 marks a sop that interrupted an open packet.
    err_base = in_startofpacket ? {5'b00000, st_q == StInPkt} : err_q;
    err_new  = err_base | {in_error,
                           cnt_sat,
                           in_endofpacket & (cnt_new < MinB),
                           cnt_new > MaxB,
                           ~in_endofpacket & (in_empty != 2'b00),
                           1'b0};

    beat.data  = in_data;
    beat.sop   = in_startofpacket;
    beat.eop   = in_endofpacket;
    beat.empty = in_empty;
    beat.error = in_endofpacket ? err_new : 6'b000000;
  end

  // Framing FSM next state.
  always_comb begin
    st_d      = st_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    beat_fwd  = 1'b0;
    stat_drop = 1'b0;
    stat_pkt  = 1'b0;
    if (acc) begin
      stat_pkt = in_endofpacket;
      if (st_q == StIdle && !in_startofpacket) begin
        stat_drop = 1'b1;
      end else begin
        beat_fwd = 1'b1;
        cnt_d    = cnt_new;
        err_d    = in_endofpacket ? 6'b000000 : err_new;
        st_d     = in_endofpacket ? StIdle : StInPkt;
      end
    end
  end

  // Output slot plus skid slot; the skid only fills when the output slot is stalled.
  always_comb begin
    out_fire     = out_valid_q & out_ready;
    out_valid_d  = out_valid_q;
    out_d        = out_q;
    skid_valid_d = skid_valid_q;
    skid_d       = skid_q;
    if (skid_valid_q) begin
      if (out_fire) begin
        out_d        = skid_q;
        skid_valid_d = 1'b0;
      end
    end else if (beat_fwd) begin
      if (!out_valid_q || out_fire) begin
        out_d       = beat;
        out_valid_d = 1'b1;
      end else begin
        skid_d       = beat;
        skid_valid_d = 1'b1;
      end
    end else if (out_fire) begin
      out_valid_d = 1'b0;
    end
    in_ready_d = ~skid_valid_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q         <= StIdle;
      cnt_q        <= '0;
      err_q        <= '0;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      out_q        <= '0;
      skid_valid_q <= 1'b0;
      skid_q       <= '0;
    end else begin
      st_q         <= st_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
      out_q        <= out_d;
      skid_valid_q <= skid_valid_d;
      skid_q       <= skid_d;
    end
  end

  assign in_ready          = in_ready_q;
  assign out_valid         = out_valid_q;
  assign out_data          = out_q.data;
  assign out_error         = out_q.error;
  assign out_startofpacket = out_q.sop;
  assign out_endofpacket   = out_q.eop;
  assign out_empty         = out_q.empty;

endmodule

// File: tb/tb_ethernet_st_frame_checker.sv
// Randomized bench for ethernet_st_frame_checker with a packet-level reference model.
module tb_ethernet_st_frame_checker;

  localparam int MinB   = 64;
  localparam int MaxB   = 1518;
  localparam int SatMax = 65535;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_ready;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_startofpacket;
  logic        in_endofpacket;
  logic [1:0]  in_empty;
  logic        in_error;
  logic        out_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic [5:0]  out_error;
  logic        out_startofpacket;
  logic        out_endofpacket;
  logic [1:0]  out_empty;
  logic        stat_drop;
  logic        stat_pkt;

  always #5 clk = ~clk;

  ethernet_st_frame_checker dut (
    .clk               (clk),
    .reset             (reset),
    .in_ready          (in_ready),
    .in_valid          (in_valid),
    .in_data           (in_data),
    .in_startofpacket  (in_startofpacket),
    .in_endofpacket    (in_endofpacket),
    .in_empty          (in_empty),
    .in_error          (in_error),
    .out_ready         (out_ready),
    .out_valid         (out_valid),
    .out_data          (out_data),
    .out_error         (out_error),
    .out_startofpacket (out_startofpacket),
    .out_endofpacket   (out_endofpacket),
    .out_empty         (out_empty),
    .stat_drop         (stat_drop),
    .stat_pkt          (stat_pkt)
  );

  typedef struct packed {
    logic [31:0] data;
    logic        sop;
    logic        eop;
    logic [1:0]  empty;
    logic        err;
  } stim_t;

  stim_t       stim_q[$];
  logic [41:0] exp_q[$];
  int          stamp_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          drops = 0;
  bit          m_in_pkt = 0;
  int          m_bytes = 0;
  logic [5:0]  m_flags = '0;
  bit          hold_pend = 0;
  logic [42:0] hold_val;
  logic [5:0]  last_eop_err;
  logic [1:0]  last_eop_empty;
  bit          lat_chk = 0;
  bit          rand_rdy = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference: packet-level framing and byte accounting with plain integers.
  function automatic void model_accept(input stim_t s, output bit fwd, output logic [41:0] e);
    fwd = 0;
    e   = '0;
    if (!m_in_pkt && !s.sop) return;
    fwd = 1;
    if (s.sop) begin
      m_flags = m_in_pkt ? 6'b000001 : 6'b000000;
      m_bytes = 0;
    end
    m_bytes = m_bytes + 4 - (s.eop ? int'(s.empty) : 0);
    if (m_bytes >= SatMax) begin
      m_bytes    = SatMax;
      m_flags[4] = 1'b1;
    end
    if (!s.eop && s.empty != 2'b00) m_flags[1] = 1'b1;
    if (m_bytes > MaxB) m_flags[2] = 1'b1;
    if (s.eop && m_bytes < MinB) m_flags[3] = 1'b1;
    if (s.err) m_flags[5] = 1'b1;
    e = {s.eop ? m_flags : 6'b000000, s.empty, s.eop, s.sop, s.data};
    m_in_pkt = !s.eop;
  endfunction

  task automatic cycle(input bit v, input stim_t s, output bit acc);
    bit          fwd;
    logic [41:0] e;
    logic [41:0] obs;
    int          st;
    @(negedge clk);
    in_valid         = v;
    in_data          = s.data;
    in_startofpacket = s.sop;
    in_endofpacket   = s.eop;
    in_empty         = s.empty;
    in_error         = s.err;
    out_ready        = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    #1;
    obs = {out_error, out_empty, out_endofpacket, out_startofpacket, out_data};
    check_eq("in_ready", 64'(in_ready), 64'(exp_q.size() < 2));
    if (hold_pend) check_eq("hold", 64'({out_valid, obs}), 64'(hold_val));
    hold_pend = out_valid && !out_ready;
    hold_val  = {out_valid, obs};
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("spurious_beat", 64'(exp_q.size()), 64'd1);
      end else begin
        check_eq("beat", 64'(obs), 64'(exp_q.pop_front()));
        st = stamp_q.pop_front();
        if (lat_chk) check_eq("latency", 64'(cyc - st), 64'd1);
        if (out_endofpacket) begin
          last_eop_err   = out_error;
          last_eop_empty = out_empty;
        end
      end
    end
    acc = v && in_ready;
    fwd = 0;
    e   = '0;
    if (acc) model_accept(s, fwd, e);
    if (fwd) begin
      exp_q.push_back(e);
      stamp_q.push_back(cyc);
    end
    check_eq("stat_drop", 64'(stat_drop), 64'(acc && !fwd));
    check_eq("stat_pkt", 64'(stat_pkt), 64'(acc && s.eop));
    if (stat_drop) drops++;
    cyc++;
  endtask

  task automatic add_frame(input int beats, input int last_empty, input int err_beat,
                           input bit term);
    for (int i = 0; i < beats; i++) begin
      stim_t s;
      s.data  = $urandom;
      s.sop   = (i == 0);
      s.eop   = term && (i == beats - 1);
      s.empty = s.eop ? 2'(last_empty) : 2'b00;
      s.err   = (i == err_beat);
      stim_q.push_back(s);
    end
  endtask

  task automatic run_stim(input int gap_pct);
    bit    acc;
    stim_t s;
    stim_t idle;
    int    guard;
    idle  = '0;
    guard = 0;
    while (stim_q.size() > 0 && guard < 20000) begin
      s = stim_q[0];
      if (int'($urandom_range(0, 99)) < gap_pct) begin
        cycle(1'b0, s, acc);
      end else begin
        cycle(1'b1, s, acc);
        if (acc) stim_q.delete(0);
      end
      guard++;
    end
    check_eq("stim_timeout", 64'(stim_q.size()), 64'd0);
    guard = 0;
    while (exp_q.size() > 0 && guard < 200) begin
      cycle(1'b0, idle, acc);
      guard++;
    end
    check_eq("drain", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    stamp_q.delete();
    stim_q.delete();
    m_in_pkt  = 0;
    m_flags   = '0;
    hold_pend = 0;
    #1;
    check_eq("rst_outs", 64'({out_valid, out_data, out_error, out_startofpacket,
                              out_endofpacket, out_empty, stat_drop, stat_pkt}), 64'd0);
    check_eq("rst_in_ready", 64'(in_ready), 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit    acc;
    stim_t s;
    reset            = 1'b1;
    in_valid         = 1'b0;
    in_data          = '0;
    in_startofpacket = 1'b0;
    in_endofpacket   = 1'b0;
    in_empty         = '0;
    in_error         = 1'b0;
    out_ready        = 1'b1;
    do_reset();

    // 1: minimum-size good frame, full throughput, 1-cycle latency
    lat_chk = 1;
    last_eop_err = 6'h3f;
    add_frame(16, 0, -1, 1'b1);
    run_stim(0);
    check_eq("t1_eop_err", 64'(last_eop_err), 64'h00);

    // 2: 61-byte frame -> undersize
    last_eop_err = 6'h3f;
    add_frame(16, 3, -1, 1'b1);
    run_stim(0);
    check_eq("t2_eop_err", 64'(last_eop_err), 64'b001000);
    check_eq("t2_eop_empty", 64'(last_eop_empty), 64'd3);

    // 3: 1520-byte frame -> oversize
    last_eop_err = 6'h3f;
    add_frame(380, 0, -1, 1'b1);
    run_stim(0);
    check_eq("t3_eop_err", 64'(last_eop_err), 64'b000100);

    // 4: three stray beats then a good frame
    drops = 0;
    last_eop_err = 6'h3f;
    for (int i = 0; i < 3; i++) begin
      s       = '0;
      s.data  = $urandom;
      stim_q.push_back(s);
    end
    add_frame(16, 0, -1, 1'b1);
    run_stim(0);
    check_eq("t4_drops", 64'(drops), 64'd3);
    check_eq("t4_eop_err", 64'(last_eop_err), 64'h00);

    // 5: random backpressure over 10 frames, then reset mid-frame
    lat_chk  = 0;
    rand_rdy = 1;
    for (int f = 0; f < 10; f++) begin
      add_frame(int'($urandom_range(10, 40)), int'($urandom_range(0, 3)),
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 9)) : -1, 1'b1);
    end
    run_stim(25);
    add_frame(30, 0, -1, 1'b1);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, stim_q[0], acc);
      if (acc) stim_q.delete(0);
    end
    do_reset();
    rand_rdy = 0;
    lat_chk  = 1;
    last_eop_err = 6'h3f;
    add_frame(16, 0, -1, 1'b1);
    run_stim(0);
    check_eq("t5_post_rst_err", 64'(last_eop_err), 64'h00);

    // 6: unterminated frame interrupted by a new sop carrying an upstream error
    last_eop_err = 6'h3f;
    add_frame(5, 0, -1, 1'b0);
    add_frame(16, 0, 2, 1'b1);
    run_stim(0);
    check_eq("t6_eop_err", 64'(last_eop_err), 64'b100001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
